// File: rtl/aes_spi_pkg.sv
// ---------------------------------------------------------------------------
// aes_spi_pkg
// Shared constants for the AES SPI master.
//   FRAME_W              : bits per chip-select window
//   DATA_MSB/PARAM_MSB/KEY_MSB : MSB positions of the three frame fields
//   PARAM_AES128/192/256 : key-size parameter byte values
//   state_t + IDLE..GAP  : master FSM state encoding
// No configuration macros are used in this file.
// ---------------------------------------------------------------------------
package aes_spi_pkg;

  localparam int FRAME_W   = 392;

  // Frame layout: data[391:264], key-size param[263:256], key[255:0].
  localparam int DATA_MSB  = 391;
  localparam int PARAM_MSB = 263;
  localparam int KEY_MSB   = 255;

  localparam logic [7:0] PARAM_AES128 = 8'd16;
  localparam logic [7:0] PARAM_AES192 = 8'd24;
  localparam logic [7:0] PARAM_AES256 = 8'd32;

  // Plain localparam encoding keeps the state visible to older tools.
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t XFER  = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t GAP   = 3'd4;

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Half-period divider for the SPI clock. Counts CLK_DIV clk cycles per sclk
// half-period and flags the cycle before each sclk transition.
//   clk      : system clock
//   reset    : synchronous, active-low reset
//   enable   : run the divider
//   clear    : force count and sclk back to zero (wins over enable)
//   rise_stb : one-cycle strobe, sclk goes high on the coming clk edge
//   fall_stb : one-cycle strobe, sclk goes low on the coming clk edge
//   sclk     : registered SPI clock, idle low
// No configuration macros are used in this file.
// ---------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic rise_stb,
  output logic fall_stb,
  output logic sclk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  // Strobes are not gated by clear, so the master may use a would-be rise
  // as a pure half-period tick and squash the sclk toggle with clear.
  always_comb begin
    wrap     = enable && (cnt_q == CNT_LAST);
    rise_stb = wrap && !sclk_q;
    fall_stb = wrap && sclk_q;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    if (clear) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (enable) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/aes_spi_master.sv
// ---------------------------------------------------------------------------
// aes_spi_master
// SPI mode-0, MSB-first master that shifts one FRAME_W-bit request frame
// out on mosi while capturing the FRAME_W-bit response from miso.
//   clk      : system clock, all logic on posedge
//   reset    : synchronous, active-low reset (aborts a frame in flight)
//   start    : request a frame, accepted when idle or at the end of GAP
//   tx_frame : frame to send, sampled on the accept cycle
//   miso     : serial data from the slave
//   loopback : (only with AES_SPI_MASTER_LOOPBACK_EN) capture mosi instead
//              of miso for the frame, sampled on the accept cycle
//   sclk     : SPI clock, idle low
//   mosi     : serial data to the slave
//   cs       : chip select, active low
//   busy     : high from the accept cycle through the end of GAP
//   done     : one-cycle pulse when the frame completes
//   rx_frame : captured response, stable from done to the next done
// Optional feature macro: AES_SPI_MASTER_LOOPBACK_EN
// ---------------------------------------------------------------------------
module aes_spi_master #(
  parameter int FRAME_W = aes_spi_pkg::FRAME_W,
  parameter int CLK_DIV = 4,
  parameter int GAP_HP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_frame,
  input  logic               miso,
`ifdef AES_SPI_MASTER_LOOPBACK_EN
  input  logic               loopback,
`endif
  output logic               sclk,
  output logic               mosi,
  output logic               cs,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_frame
);

  import aes_spi_pkg::*;

  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = $clog2(GAP_HP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_HP - 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0] rx_frame_q, rx_frame_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
  logic               lb_q, lb_d;
`endif

  logic rise_stb, fall_stb;
  logic div_en, div_clr;
  logic gap_end, accept, miso_bit;

  // In HOLD and GAP the divider only marks half-periods: every would-be
  // rise is squashed by clear, so sclk stays low while cs is high.
  always_comb begin
    div_en   = (state_q != IDLE);
    div_clr  = (state_q == IDLE) ||
               (rise_stb && ((state_q == HOLD) || (state_q == GAP)));
    gap_end  = (state_q == GAP) && rise_stb && (gap_cnt_q == GAP_LAST);
    accept   = start && ((state_q == IDLE) || gap_end);
`ifdef AES_SPI_MASTER_LOOPBACK_EN
    miso_bit = lb_q ? tx_shift_q[FRAME_W-1] : miso;
`else
    miso_bit = miso;
`endif
  end

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (div_en),
    .clear    (div_clr),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .sclk     (sclk)
  );

  // Frame sequencing. mosi is the MSB of tx_shift, so skipping the shift on
  // the last fall holds the last bit through HOLD, and clearing tx_shift at
  // done returns mosi to 0.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_frame_d = rx_frame_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    cs_d       = cs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
    lb_d       = lb_q;
`endif
    case (state_q)
      IDLE: begin
      end
      SETUP, XFER: begin
        if (rise_stb) begin
          rx_shift_d = {rx_shift_q[FRAME_W-2:0], miso_bit};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          state_d    = XFER;
        end else if (fall_stb) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            tx_shift_d = {tx_shift_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (rise_stb) begin
          cs_d       = 1'b1;
          tx_shift_d = '0;
          rx_frame_d = rx_shift_q;
          done_d     = 1'b1;
          gap_cnt_d  = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (rise_stb) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A start seen in the last GAP cycle is taken directly, so a held start
    // gives back-to-back frames with exactly the minimum cs-high gap.
    if (accept) begin
      tx_shift_d = tx_frame;
      bit_cnt_d  = '0;
      cs_d       = 1'b0;
      busy_d     = 1'b1;
      state_d    = SETUP;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
      lb_d       = loopback;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_frame_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_frame_q <= rx_frame_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef AES_SPI_MASTER_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  assign mosi     = tx_shift_q[FRAME_W-1];
  assign cs       = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_frame = rx_frame_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// ---------------------------------------------------------------------------
// tb_aes_spi_master
// Directed bench for aes_spi_master: a small instance (FRAME_W=8, CLK_DIV=2,
// GAP_HP=2) for timing and reset cases, and a default-sized instance for the
// full AES frame. Simple mode-0 slave models drive miso and record mosi.
// Optional feature macro: AES_SPI_MASTER_LOOPBACK_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_spi_master;
  import aes_spi_pkg::*;

  localparam int CW = 392;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small instance signals
  logic       s_start = 1'b0;
  logic [7:0] s_tx = '0;
  logic       s_miso = 1'b0;
  logic       s_sclk, s_mosi, s_cs, s_busy, s_done;
  logic [7:0] s_rx;

  // Full-size instance signals
  logic          f_start = 1'b0;
  logic [391:0]  f_tx = '0;
  logic          f_miso;
  logic          f_miso_model = 1'b0;
  logic          f_lb = 1'b0;
  logic          f_sclk, f_mosi, f_cs, f_busy, f_done;
  logic [391:0]  f_rx;

  assign f_miso = f_lb ? 1'b0 : f_miso_model;

  aes_spi_master #(.FRAME_W(8), .CLK_DIV(2), .GAP_HP(2)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .start    (s_start),
    .tx_frame (s_tx),
    .miso     (s_miso),
`ifdef AES_SPI_MASTER_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .sclk     (s_sclk),
    .mosi     (s_mosi),
    .cs       (s_cs),
    .busy     (s_busy),
    .done     (s_done),
    .rx_frame (s_rx)
  );

  aes_spi_master dut_full (
    .clk      (clk),
    .reset    (reset),
    .start    (f_start),
    .tx_frame (f_tx),
    .miso     (f_miso),
`ifdef AES_SPI_MASTER_LOOPBACK_EN
    .loopback (f_lb),
`endif
    .sclk     (f_sclk),
    .mosi     (f_mosi),
    .cs       (f_cs),
    .busy     (f_busy),
    .done     (f_done),
    .rx_frame (f_rx)
  );

  // Small slave: load the response on cs fall, shift on sclk fall, and
  // record mosi on every sclk rise.
  logic [7:0] s_resp = '0;
  logic [7:0] s_slave_sr = '0;
  logic [7:0] s_mosi_cap = '0;
  int s_rises = 0;
  int s_stray = 0;

  always @(negedge s_cs) begin
    s_slave_sr = s_resp;
    s_miso     = s_slave_sr[7];
  end
  always @(negedge s_sclk) begin
    if (!s_cs) begin
      s_slave_sr = {s_slave_sr[6:0], 1'b0};
      s_miso     = s_slave_sr[7];
    end
  end
  always @(posedge s_sclk) begin
    s_mosi_cap = {s_mosi_cap[6:0], s_mosi};
    s_rises++;
    if (s_cs) s_stray++;
  end

  // Full-size slave, same behaviour at 392 bits.
  logic [391:0] f_resp = '0;
  logic [391:0] f_slave_sr = '0;
  logic [391:0] f_mosi_cap = '0;
  int f_rises = 0;

  always @(negedge f_cs) begin
    f_slave_sr   = f_resp;
    f_miso_model = f_slave_sr[391];
  end
  always @(negedge f_sclk) begin
    if (!f_cs) begin
      f_slave_sr   = {f_slave_sr[390:0], 1'b0};
      f_miso_model = f_slave_sr[391];
    end
  end
  always @(posedge f_sclk) begin
    f_mosi_cap = {f_mosi_cap[390:0], f_mosi};
    f_rises++;
  end

  // Per-run observations of the small instance, in cycles after T0
  int s_first_low, s_first_rise, s_second_low;
  int s_done_at, s_done2_at, s_done_cnt;
  logic s_busy_at1, s_prev_cs;
  int f_done_at, f_done_cnt;

  // Comparison helper: counts the check, reports a mismatch via $error.
  task automatic checkOutput(input string tag, input logic [391:0] observed,
                             input logic [391:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the small instance's request at a negedge; this cycle is T0.
  task automatic applyStimulus(input logic start_v, input logic [7:0] tx_v);
    @(negedge clk);
    s_start = start_v;
    s_tx    = tx_v;
  endtask

  // Start a small frame, drop start at cycle stop_at, observe ncyc cycles.
  task automatic runSmall(input logic [7:0] tx, input int stop_at, input int ncyc);
    s_first_low  = -1;
    s_first_rise = -1;
    s_second_low = -1;
    s_done_at    = -1;
    s_done2_at   = -1;
    s_done_cnt   = 0;
    s_busy_at1   = 1'b0;
    s_prev_cs    = 1'b1;
    s_mosi_cap   = '0;
    s_rises      = 0;
    s_stray      = 0;
    applyStimulus(1'b1, tx);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == stop_at) s_start = 1'b0;
      if (n == 1) s_busy_at1 = s_busy;
      if (!s_cs && s_prev_cs) begin
        if (s_first_low < 0) s_first_low = n;
        else if (s_second_low < 0) s_second_low = n;
      end
      if (s_cs && !s_prev_cs && s_first_rise < 0) s_first_rise = n;
      if (s_done) begin
        s_done_cnt++;
        if (s_done_at < 0) s_done_at = n;
        else if (s_done2_at < 0) s_done2_at = n;
      end
      s_prev_cs = s_cs;
    end
  endtask

  // Start a full-size frame and observe ncyc cycles.
  task automatic runFull(input logic [391:0] tx, input int ncyc);
    f_done_at  = -1;
    f_done_cnt = 0;
    f_mosi_cap = '0;
    f_rises    = 0;
    @(negedge clk);
    f_start = 1'b1;
    f_tx    = tx;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) f_start = 1'b0;
      if (f_done) begin
        f_done_cnt++;
        if (f_done_at < 0) f_done_at = n;
      end
    end
  endtask

  logic [391:0] aes_tx, aes_resp;
  logic [415:0] rnd;

  initial begin
    $display("[TB] start");

    // Reset held with start high: outputs stay in the idle state.
    reset   = 1'b0;
    s_start = 1'b1;
    f_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_cs",   CW'(s_cs),   CW'(1'b1));
      checkOutput("rst_sclk", CW'(s_sclk), CW'(1'b0));
      checkOutput("rst_busy", CW'(s_busy), CW'(1'b0));
      checkOutput("rst_done", CW'(s_done), CW'(1'b0));
      checkOutput("rst_rx",   CW'(s_rx),   CW'(8'h00));
    end
    checkOutput("rst_full_cs", CW'(f_cs), CW'(1'b1));
    checkOutput("rst_full_rx", f_rx, CW'(0));
    reset   = 1'b1;
    s_start = 1'b0;
    f_start = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame: tx A5, slave returns 3C.
    s_resp = 8'h3C;
    runSmall(8'hA5, 1, 50);
    checkOutput("one_busy_t1",  CW'(s_busy_at1),   CW'(1'b1));
    checkOutput("one_cs_fall",  CW'(s_first_low),  CW'(1));
    checkOutput("one_cs_rise",  CW'(s_first_rise), CW'(35));
    checkOutput("one_done_at",  CW'(s_done_at),    CW'(35));
    checkOutput("one_done_cnt", CW'(s_done_cnt),   CW'(1));
    checkOutput("one_mosi",     CW'(s_mosi_cap),   CW'(8'hA5));
    checkOutput("one_rises",    CW'(s_rises),      CW'(8));
    checkOutput("one_stray",    CW'(s_stray),      CW'(0));
    checkOutput("one_rx",       CW'(s_rx),         CW'(8'h3C));
    checkOutput("one_idle",     CW'(s_busy),       CW'(1'b0));
    checkOutput("one_mosi_idle", CW'(s_mosi),      CW'(1'b0));

    // Back-to-back: start held until cycle 50, inside the second frame.
    s_resp = 8'hC3;
    runSmall(8'h5A, 50, 120);
    checkOutput("b2b_cs_rise",  CW'(s_first_rise), CW'(35));
    checkOutput("b2b_cs_fall2", CW'(s_second_low), CW'(39));
    checkOutput("b2b_done1",    CW'(s_done_at),    CW'(35));
    checkOutput("b2b_done2",    CW'(s_done2_at),   CW'(73));
    checkOutput("b2b_done_cnt", CW'(s_done_cnt),   CW'(2));
    checkOutput("b2b_rises",    CW'(s_rises),      CW'(16));
    checkOutput("b2b_mosi",     CW'(s_mosi_cap),   CW'(8'h5A));
    checkOutput("b2b_rx",       CW'(s_rx),         CW'(8'hC3));
    checkOutput("b2b_idle",     CW'(s_busy),       CW'(1'b0));

    // Reset during the fifth sclk-high phase aborts the frame.
    s_resp  = 8'h3C;
    s_rises = 0;
    applyStimulus(1'b1, 8'hA5);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) s_start = 1'b0;
      if (s_rises == 5 && s_sclk) break;
    end
    checkOutput("mid_rises", CW'(s_rises), CW'(5));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_cs",   CW'(s_cs),   CW'(1'b1));
    checkOutput("mid_sclk", CW'(s_sclk), CW'(1'b0));
    checkOutput("mid_busy", CW'(s_busy), CW'(1'b0));
    checkOutput("mid_rx",   CW'(s_rx),   CW'(8'h00));
    reset = 1'b1;
    s_done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s_done) s_done_cnt++;
    end
    checkOutput("mid_no_done", CW'(s_done_cnt), CW'(0));

    // Frame after the abort completes normally.
    s_resp = 8'h96;
    runSmall(8'hFF, 1, 50);
    checkOutput("post_done_at", CW'(s_done_at),  CW'(35));
    checkOutput("post_mosi",    CW'(s_mosi_cap), CW'(8'hFF));
    checkOutput("post_rx",      CW'(s_rx),       CW'(8'h96));

    // Full AES frame: FIPS-197 plaintext, param 16, AES-128 key padded.
    aes_tx = '0;
    aes_tx[DATA_MSB -: 128]  = 128'h00112233445566778899aabbccddeeff;
    aes_tx[PARAM_MSB -: 8]   = PARAM_AES128;
    aes_tx[KEY_MSB -: 128]   = 128'h000102030405060708090a0b0c0d0e0f;
    aes_resp = '0;
    aes_resp[DATA_MSB -: 128] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    aes_resp[PARAM_MSB -: 8]  = PARAM_AES128;
    aes_resp[KEY_MSB -: 128]  = 128'h000102030405060708090a0b0c0d0e0f;
    f_resp = aes_resp;
    runFull(aes_tx, 3160);
    checkOutput("aes_done_at",  CW'(f_done_at),  CW'(1 + 785 * 4));
    checkOutput("aes_done_cnt", CW'(f_done_cnt), CW'(1));
    checkOutput("aes_rises",    CW'(f_rises),    CW'(392));
    checkOutput("aes_mosi",     f_mosi_cap,      aes_tx);
    checkOutput("aes_rx",       f_rx,            aes_resp);
    checkOutput("aes_idle",     CW'(f_busy),     CW'(1'b0));

`ifdef AES_SPI_MASTER_LOOPBACK_EN
    // Loopback: miso forced low, rx must equal the transmitted frame.
    for (int i = 0; i < 13; i++) rnd[i*32 +: 32] = $urandom;
    f_lb = 1'b1;
    runFull(rnd[391:0], 3160);
    checkOutput("lb_done_at", CW'(f_done_at), CW'(1 + 785 * 4));
    checkOutput("lb_rx",      f_rx,           rnd[391:0]);
    f_lb = 1'b0;
`else
    rnd = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_spi_master.md
Name: aes_spi_master

Overview:
- SPI master that drives the AES SPI slave frame interface from the host/test side.
- Serialises one FRAME_W-bit request frame: data[391:264], key-size param[263:256], key[255:0].
- Simultaneously captures the FRAME_W-bit response frame returned on miso.
- SPI mode 0, MSB first; one frame per cs-low window; the host sequences encrypt/decrypt frames.

Parameters:
- FRAME_W, 392, bits per cs-low frame (legal ≥ 2)
- CLK_DIV, 4, clk cycles per sclk half-period (legal ≥ 2)
- GAP_HP, 2, minimum cs-high half-periods between frames (legal ≥ 1)

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a frame; accepted only when busy=0.
- tx_frame  input  FRAME_W  frame to send; sampled only on the accept cycle.
- miso  input  1  serial data from slave.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  serial data to slave.
- cs  output  1  chip select, active low.
- busy  output  1  high from the accept cycle through end of GAP.
- done  output  1  one-cycle pulse when the frame completes.
- rx_frame  output  FRAME_W  captured response; stable from done until the next done.

Behaviour:
- Reset (reset=0 at posedge), including mid-frame: abort immediately. Next cycle: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_frame=0, state IDLE, all counters cleared.
- States: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
- IDLE: cs=1, sclk=0.
  - start=1 in cycle T0: latch tx_frame into the shift register; busy=1 from T0+1; go to SETUP.
  - start while busy=1 is ignored; no queuing.
- SETUP, from T0+1:
  - cs=0; mosi=shift[FRAME_W-1].
  - Wait CLK_DIV cycles, then go to XFER.
- XFER: divider counts 0..CLK_DIV-1; sclk toggles when the count wraps.
  - Rising edge of sclk: on the same clk edge that sets sclk=1, shift the current miso into rx_shift LSB.
  - Falling edge: shift tx left; mosi = next bit.
  - Bit counter counts rising edges.
  - After the FRAME_W-th falling edge, go to HOLD; mosi is held at the last bit.
- First sclk rise occurs at T0+1+CLK_DIV. Last sclk fall occurs at T0+1+2*FRAME_W*CLK_DIV.
- HOLD:
  - Wait CLK_DIV cycles.
  - Then cs=1 and mosi=0; rx_frame<=rx_shift and done=1 for exactly one cycle, at T0+1+(2*FRAME_W+1)*CLK_DIV.
  - Go to GAP.
- GAP:
  - cs=1 for GAP_HP*CLK_DIV cycles, then go to IDLE and busy=0.
  - A start asserted in the cycle busy falls is accepted.
- Exactly FRAME_W rising edges per frame; no sclk edges while cs=1.
- rx bit order: first received bit ends in rx_frame[FRAME_W-1].
- Counters:
  - divider width = clog2(CLK_DIV)
  - bit counter width = clog2(FRAME_W+1); no wrap within a frame

Optional Feature:
- Macro: AES_SPI_MASTER_LOOPBACK_EN.
- Defined: additional input loopback (1 bit), sampled at accept.
  - When loopback=1, miso is ignored and the mosi bit is sampled internally instead, so rx_frame==tx_frame at done.
  - sclk, cs and mosi timing are unchanged.
- Undefined: no port, no mux; behaviour exactly as above.

Decomposition:
- Package aes_spi_pkg holds:
  - FRAME_W=392
  - field offsets DATA_MSB=391, PARAM_MSB=263, KEY_MSB=255
  - PARAM values 16/24/32
  - state enum IDLE/SETUP/XFER/HOLD/GAP
- Sub-module spi_clk_div (parameter CLK_DIV):
  - inputs: enable, clear
  - outputs: one-cycle rise_stb and fall_stb, plus registered sclk
  - the master FSM uses only these strobes.

Test Plan:
- Reset and start: FRAME_W=8, CLK_DIV=2. Hold reset=0 for 3 cycles while start=1 -> cs=1, sclk=0, busy=0, done=0, rx_frame=0 throughout.
- Single frame timing: FRAME_W=8, CLK_DIV=2, tx_frame=8'hA5, slave model returns 8'h3C.
  - Expect mosi bits 1,0,1,0,0,1,0,1 at the rising edges.
  - Expect cs low T0+1..T0+34, done at T0+35, rx_frame=8'h3C.
- Back-to-back requests: start held high continuously, GAP_HP=2, CLK_DIV=2 -> second cs fall exactly 4 cycles after the first cs rise; start during busy is ignored (no extra frame).
- Reset mid-frame: reset=0 at the 5th rising edge -> cs=1 and sclk=0 next cycle, no done. The next frame with tx=8'hFF completes normally.
- Full AES frame: defaults, tx = FIPS-197 plaintext 00112233445566778899aabbccddeeff, param=16, key 000102..0f padded.
  - Exactly 392 sclk rises, done at T0+1+785*4.
  - rx_frame matches the slave model's echo.
- Loopback (macro defined): loopback=1, tx=random 392 bits, miso tied 0 -> rx_frame==tx.
